regbank_wr_arbiter: RTL and testbench

Shared-write controller for a small bank of wide flip-flop registers. Two requesters write bursts into the bank, and a round-robin arbiter decides which requester owns the bank for each burst. A registered state machine sequences the beats and wraps the address inside the bank. The bank contents are exposed in flattened form and through one combinational read port. The block sits in front of a group of enable-style registers, and its clear value is fixed by parameter.

---
 rtl/regbank_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regbank_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter
//
// Shared-write controller for a small bank of WIDTH-bit flip-flop registers.
// Two requesters (A and B) write bursts into the bank. A round-robin
// arbiter picks the owner of the bank for each burst, and a registered
// state machine walks the beats, wrapping the write address inside the bank.
//
// Parameters:
//   WIDTH  data width of each entry
//   AW     address width, DEPTH = 2**AW entries
//   INIT   value loaded into every entry on clear
//
// Ports:
//   clk                  rising-edge clock
//   clr                  synchronous active-high clear
//   a_req / b_req        burst request (level)
//   a_addr / b_addr      burst start address, sampled at grant
//   a_len / b_len        burst beats minus one, sampled at grant
//   a_wdata / b_wdata    write data
//   a_wvalid / b_wvalid  beat valid
//   a_gnt / b_gnt        requester owns the bank (registered)
//   a_done / b_done      one-cycle pulse after the requester's final beat
//   rd_addr              read address
//   rd_data              entry[rd_addr], combinational
//   q                    flattened bank, entry i at q[i*WIDTH +: WIDTH]
//   busy                 a burst is in progress
module regbank_wr_arbiter #(
    parameter int              WIDTH = 4,
    parameter int              AW    = 2,
    parameter logic [WIDTH-1:0] INIT = 4'b0110
) (
    input  logic                        clk,
    input  logic                        clr,

    input  logic                        a_req,
    input  logic [AW-1:0]               a_addr,
    input  logic [AW-1:0]               a_len,
    input  logic [WIDTH-1:0]            a_wdata,
    input  logic                        a_wvalid,
    output logic                        a_gnt,
    output logic                        a_done,

    input  logic                        b_req,
    input  logic [AW-1:0]               b_addr,
    input  logic [AW-1:0]               b_len,
    input  logic [WIDTH-1:0]            b_wdata,
    input  logic                        b_wvalid,
    output logic                        b_gnt,
    output logic                        b_done,

    input  logic [AW-1:0]               rd_addr,
    output logic [WIDTH-1:0]            rd_data,
    output logic [(2**AW)*WIDTH-1:0]    q,
    output logic                        busy
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    state_t           state;
    pri_t             pri;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    len;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             arb_a;

    // Beat source of the current owner. Signals of the requester that does
    // not own the bank never reach the write path, and nothing is selected
    // while idle, so stray wvalids are ignored by construction.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        case (state)
            GNT_A: begin
                sel_valid = a_wvalid;
                sel_data  = a_wdata;
            end
            GNT_B: begin
                sel_valid = b_wvalid;
                sel_data  = b_wdata;
            end
            default: begin
                sel_valid = 1'b0;
                sel_data  = '0;
            end
        endcase
    end

    // A wins when it is the only requester, or when both request and A
    // holds the priority flag.
    assign arb_a = a_req && (!b_req || (pri == PRI_A));

    // Sequencer and bank. Clear wins over any beat in the same cycle, so a
    // burst interrupted by clear leaves no trace and produces no done.
    // done is cleared every cycle and only set by a final beat, which makes
    // it a single-cycle pulse that coincides with the return to IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            pri    <= PRI_A;
            ptr    <= '0;
            len    <= '0;
            cnt    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT;
            end
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_a) begin
                        state <= GNT_A;
                        ptr   <= a_addr;
                        len   <= a_len;
                        cnt   <= '0;
                    end else if (b_req) begin
                        state <= GNT_B;
                        ptr   <= b_addr;
                        len   <= b_len;
                        cnt   <= '0;
                    end
                end
                GNT_A, GNT_B: begin
                    if (sel_valid) begin
                        mem[ptr] <= sel_data;
                        // Natural AW-bit overflow gives the wrap inside the bank.
                        ptr      <= ptr + 1'b1;
                        cnt      <= cnt + 1'b1;
                        if (cnt == len) begin
                            state <= IDLE;
                            if (state == GNT_A) begin
                                a_done <= 1'b1;
                                pri    <= PRI_B;
                            end else begin
                                b_done <= 1'b1;
                                pri    <= PRI_A;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign a_gnt   = (state == GNT_A);
    assign b_gnt   = (state == GNT_B);
    assign busy    = (state != IDLE);
    assign rd_data = mem[rd_addr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign q[gi*WIDTH +: WIDTH] = mem[gi];
        end
    endgenerate

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb_regbank_wr_arbiter
//
// Directed bench for regbank_wr_arbiter with a scoreboard. Each burst pushes
// the requester that should complete it and the hand-computed bank image
// into a queue; a monitor pops and compares whenever a done pulse appears.
module tb_regbank_wr_arbiter;

    logic        clk;
    logic        clr;
    logic        a_req;
    logic [1:0]  a_addr;
    logic [1:0]  a_len;
    logic [3:0]  a_wdata;
    logic        a_wvalid;
    logic        a_gnt;
    logic        a_done;
    logic        b_req;
    logic [1:0]  b_addr;
    logic [1:0]  b_len;
    logic [3:0]  b_wdata;
    logic        b_wvalid;
    logic        b_gnt;
    logic        b_done;
    logic [1:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [15:0] q;
    logic        busy;

    typedef struct packed {
        logic        is_b;
        logic [15:0] qv;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    regbank_wr_arbiter dut (
        .clk      (clk),
        .clr      (clr),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_len    (a_len),
        .a_wdata  (a_wdata),
        .a_wvalid (a_wvalid),
        .a_gnt    (a_gnt),
        .a_done   (a_done),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_len    (b_len),
        .b_wdata  (b_wdata),
        .b_wvalid (b_wvalid),
        .b_gnt    (b_gnt),
        .b_done   (b_done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .q        (q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (a_done || b_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got a_done=%0b b_done=%0b expected no done", a_done, b_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("done_source", {30'd0, a_done, b_done}, {30'd0, ~e.is_b, e.is_b});
                check_output("burst_q", {16'd0, q}, {16'd0, e.qv});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_cleared(input string tag);
        check_output({tag, "_q"}, {16'd0, q}, 32'h6666);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 32'd0);
        check_output({tag, "_done"}, {30'd0, a_done, b_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check_output({tag, "_rd"}, {28'd0, rd_data}, 32'h6);
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // One complete burst from one requester while the other one drives
    // wvalid with 4'hF to prove it cannot touch the bank. beats holds beat k
    // at beats[k*4 +: 4]; stall_after inserts one idle cycle after that beat,
    // during which the bank must equal stall_q.
    task automatic apply_stimulus(input bit use_b, input logic [1:0] addr, input logic [1:0] len,
                                  input logic [15:0] beats, input int stall_after,
                                  input logic [15:0] stall_q, input logic [15:0] exp_q);
        bit granted;
        sb.push_back('{is_b: use_b, qv: exp_q});
        if (use_b) begin
            b_req = 1'b1; b_addr = addr; b_len = len; b_wvalid = 1'b0;
            a_req = 1'b0; a_addr = 2'd0; a_len = 2'd3; a_wdata = 4'hF; a_wvalid = 1'b1;
        end else begin
            a_req = 1'b1; a_addr = addr; a_len = len; a_wvalid = 1'b0;
            b_req = 1'b0; b_addr = 2'd0; b_len = 2'd3; b_wdata = 4'hF; b_wvalid = 1'b1;
        end
        granted = 1'b0;
        for (int i = 0; i < 8 && !granted; i++) begin
            @(posedge clk);
            #1;
            if (use_b ? b_gnt : a_gnt) granted = 1'b1;
        end
        check_output("grant", {31'd0, granted}, 32'd1);
        check_output("busy_in_grant", {31'd0, busy}, 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (use_b) begin
                b_wdata = beats[k*4 +: 4]; b_wvalid = 1'b1;
            end else begin
                a_wdata = beats[k*4 +: 4]; a_wvalid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (k == stall_after) begin
                if (use_b) b_wvalid = 1'b0; else a_wvalid = 1'b0;
                @(posedge clk);
                #1;
                check_output("stall_hold", {16'd0, q}, {16'd0, stall_q});
                check_output("stall_gnt", {31'd0, use_b ? b_gnt : a_gnt}, 32'd1);
            end
        end
        a_wvalid = 1'b0;
        b_wvalid = 1'b0;
        check_output("gnt_after_last", {30'd0, a_gnt, b_gnt}, 32'd0);
        @(posedge clk);
        #1;
        check_output("done_one_cycle", {30'd0, a_done, b_done}, 32'd0);
    endtask

    initial begin
        logic [15:0] rr_exp;
        bit          granted;
        checks   = 0;
        failures = 0;
        clr = 1'b1;
        a_req = 1'b0; a_addr = '0; a_len = '0; a_wdata = '0; a_wvalid = 1'b0;
        b_req = 1'b0; b_addr = '0; b_len = '0; b_wdata = '0; b_wvalid = 1'b0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check_cleared("reset");

        $display("[TB] single beat A");
        apply_stimulus(1'b0, 2'd1, 2'd0, 16'h000A, -1, 16'h0, 16'h66A6);
        rd_addr = 2'd1; #1;
        check_output("rd_entry1", {28'd0, rd_data}, 32'hA);

        $display("[TB] wrapping B burst with a stall");
        apply_stimulus(1'b1, 2'd3, 2'd2, 16'h0321, 0, 16'h16A6, 16'h1632);

        $display("[TB] clear while idle");
        @(posedge clk); #1;
        do_clear();
        check_cleared("clear_idle");

        $display("[TB] round robin");
        sb.push_back('{is_b: 1'b0, qv: 16'h6665});
        sb.push_back('{is_b: 1'b1, qv: 16'h6765});
        a_req = 1'b1; a_addr = 2'd0; a_len = 2'd0; a_wdata = 4'h5; a_wvalid = 1'b1;
        b_req = 1'b1; b_addr = 2'd2; b_len = 2'd0; b_wdata = 4'h7; b_wvalid = 1'b1;
        @(posedge clk); #1;
        check_output("rr_first_a", {30'd0, a_gnt, b_gnt}, 32'h2);
        @(posedge clk); #1;
        check_output("rr_idle_gap", {30'd0, a_gnt, b_gnt}, 32'h0);
        @(posedge clk); #1;
        check_output("rr_then_b", {30'd0, a_gnt, b_gnt}, 32'h1);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        a_wvalid = 1'b0;
        b_wvalid = 1'b0;
        @(posedge clk); #1;
        rr_exp = 16'h6765;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check_output("rr_readback", {28'd0, rd_data}, {28'd0, rr_exp[i*4 +: 4]});
        end

        $display("[TB] clear in the middle of a burst");
        a_req = 1'b1; a_addr = 2'd0; a_len = 2'd3; a_wvalid = 1'b0;
        granted = 1'b0;
        for (int i = 0; i < 8 && !granted; i++) begin
            @(posedge clk); #1;
            if (a_gnt) granted = 1'b1;
        end
        check_output("abort_grant", {31'd0, granted}, 32'd1);
        a_req = 1'b0;
        a_wdata = 4'h9; a_wvalid = 1'b1;
        @(posedge clk); #1;
        a_wdata = 4'h8;
        @(posedge clk); #1;
        check_output("abort_partial_q", {16'd0, q}, 32'h6789);
        a_wdata = 4'h7;
        do_clear();
        a_wvalid = 1'b0;
        check_output("abort_gnt", {31'd0, a_gnt}, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_q", {16'd0, q}, 32'h6666);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_output("abort_no_done", {31'd0, a_done}, 32'd0);
        end

        $display("[TB] full-bank burst from B");
        apply_stimulus(1'b1, 2'd2, 2'd3, 16'h4321, -1, 16'h0, 16'h2143);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
